// File: rtl/gpq_pkg.sv
// Shared definitions for the graphics command queue: sequencer state
// encoding, 128-bit queue entry layout and default sizing.
package gpq_pkg;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_SETTLE  = 2;
  localparam int DEF_TIMEOUT = 1048576;

  localparam int FIELD_W  = 32;
  localparam int ENTRY_W  = 4 * FIELD_W;
  localparam int CTRL_LSB = 96;
  localparam int TL_LSB   = 64;
  localparam int BR_LSB   = 32;
  localparam int ARG_LSB  = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_W_TL   = 3'd2;
  localparam logic [2:0] ST_W_BR   = 3'd3;
  localparam logic [2:0] ST_W_ARG  = 3'd4;
  localparam logic [2:0] ST_W_CTRL = 3'd5;
  localparam logic [2:0] ST_SETTLE = 3'd6;
  localparam logic [2:0] ST_WAIT   = 3'd7;

  // Pack the four command words into one queue entry.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [FIELD_W-1:0] ctrl,
    input logic [FIELD_W-1:0] tl,
    input logic [FIELD_W-1:0] br,
    input logic [FIELD_W-1:0] arg
  );
    return {ctrl, tl, br, arg};
  endfunction

endpackage

// File: rtl/gpq_fifo.sv
// Generic synchronous FIFO. Push is accepted only when not full (judged
// before any same-cycle pop); pop is accepted only when not empty.
// Read data is the current head, valid whenever empty is low.
module gpq_fifo
  import gpq_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; data is not reset, only pointers and count are.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gp_cmd_queue.sv
// Command queue and sequencer in front of the graphics processor.
// Each queued command is replayed as tl, br, arg, ctrl register writes on
// consecutive cycles; the next command waits until the GP reports finish.
// Optional watchdog on the WAIT state: define GPQ_TIMEOUT_EN.
module gp_cmd_queue
  import gpq_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              cmd_ctrl,
  input  logic [31:0]              cmd_tl,
  input  logic [31:0]              cmd_br,
  input  logic [31:0]              cmd_arg,
  input  logic                     cmd_push,
  output logic                     cmd_full,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     busy,
  output logic                     overflow,
  input  logic                     gp_finish,
  output logic [31:0]              gp_ctrl,
  output logic [31:0]              gp_tl,
  output logic [31:0]              gp_br,
  output logic [31:0]              gp_arg,
  output logic                     gp_ctrl_we,
  output logic                     gp_tl_we,
  output logic                     gp_br_we,
  output logic                     gp_arg_we,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(SETTLE + 1) + 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  logic [2:0]         state;
  logic [SC_W-1:0]    settle_cnt;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic [ENTRY_W-1:0] head_p0;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               dispatch;
  logic               timeout_hit;

  assign push_data = pack_entry(cmd_ctrl, cmd_tl, cmd_br, cmd_arg);
  assign dispatch  = (state == ST_IDLE) && !fifo_empty && gp_finish;

  gpq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .wdata (push_data),
    .pop   (dispatch),
    .rdata (head_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_full   = fifo_full;
  assign cmd_count  = fifo_count;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  assign gp_tl_we   = (state == ST_W_TL);
  assign gp_br_we   = (state == ST_W_BR);
  assign gp_arg_we  = (state == ST_W_ARG);
  assign gp_ctrl_we = (state == ST_W_CTRL);

`ifdef GPQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] wait_cnt;
  logic            timeout_q;

  assign timeout_hit = (state == ST_WAIT) && !gp_finish && (wait_cnt == TIMEOUT_LAST);
  assign timeout_err = timeout_q;

  // Watchdog: counts stalled WAIT cycles, restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != ST_WAIT) begin
        wait_cnt <= '0;
      end else if (!gp_finish) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Sequencer: dispatch, four register writes, settle window, wait for finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:   if (dispatch) state <= ST_FETCH;
        ST_FETCH:  state <= ST_W_TL;
        ST_W_TL:   state <= ST_W_BR;
        ST_W_BR:   state <= ST_W_ARG;
        ST_W_ARG:  state <= ST_W_CTRL;
        ST_W_CTRL: begin
          settle_cnt <= '0;
          state      <= (SETTLE == 0) ? ST_WAIT : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_WAIT;
          end else begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        ST_WAIT:   if (gp_finish || timeout_hit) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow: a push arrived while the queue was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (cmd_push && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // p0: capture the popped head at dispatch, before the read pointer moves.
  always_ff @(posedge clk) begin
    if (dispatch) begin
      head_p0 <= head_data;
    end
  end

  // p1: GP data registers, loaded in FETCH and held until the next command.
  always_ff @(posedge clk) begin
    if (rst) begin
      gp_ctrl <= '0;
      gp_tl   <= '0;
      gp_br   <= '0;
      gp_arg  <= '0;
    end else if (state == ST_FETCH) begin
      gp_ctrl <= head_p0[CTRL_LSB +: FIELD_W];
      gp_tl   <= head_p0[TL_LSB   +: FIELD_W];
      gp_br   <= head_p0[BR_LSB   +: FIELD_W];
      gp_arg  <= head_p0[ARG_LSB  +: FIELD_W];
    end
  end

endmodule

// File: tb/tb_gp_cmd_queue.sv
// Directed testbench for gp_cmd_queue (DEPTH=8, SETTLE=2, TIMEOUT=16).
module tb_gp_cmd_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_ctrl, cmd_tl, cmd_br, cmd_arg;
  logic        cmd_push;
  logic        cmd_full;
  logic [3:0]  cmd_count;
  logic        busy, overflow;
  logic        gp_finish;
  logic [31:0] gp_ctrl, gp_tl, gp_br, gp_arg;
  logic        gp_ctrl_we, gp_tl_we, gp_br_we, gp_arg_we;
  logic        timeout_err;
  logic [3:0]  we_vec;

  int errors = 0;
  int checks = 0;

  // Simple GP model: after each ctrl write, finish drops for hold_len cycles.
  logic fin_manual;
  logic gp_auto;
  int   hold_len;
  int   hold = 0;

  always #5 clk = ~clk;

  assign gp_finish = fin_manual && (hold == 0);
  assign we_vec    = {gp_tl_we, gp_br_we, gp_arg_we, gp_ctrl_we};

  always @(posedge clk) begin
    if (rst) hold <= 0;
    else if (gp_auto && gp_ctrl_we) hold <= hold_len;
    else if (hold != 0) hold <= hold - 1;
  end

  gp_cmd_queue #(
    .DEPTH   (8),
    .SETTLE  (2),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_ctrl    (cmd_ctrl),
    .cmd_tl      (cmd_tl),
    .cmd_br      (cmd_br),
    .cmd_arg     (cmd_arg),
    .cmd_push    (cmd_push),
    .cmd_full    (cmd_full),
    .cmd_count   (cmd_count),
    .busy        (busy),
    .overflow    (overflow),
    .gp_finish   (gp_finish),
    .gp_ctrl     (gp_ctrl),
    .gp_tl       (gp_tl),
    .gp_br       (gp_br),
    .gp_arg      (gp_arg),
    .gp_ctrl_we  (gp_ctrl_we),
    .gp_tl_we    (gp_tl_we),
    .gp_br_we    (gp_br_we),
    .gp_arg_we   (gp_arg_we),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] c, input logic [31:0] t,
                          input logic [31:0] b, input logic [31:0] a);
    cmd_ctrl = c; cmd_tl = t; cmd_br = b; cmd_arg = a;
    cmd_push = 1'b1;
    tick();
    cmd_push = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_push = 1'b0; fin_manual = 1'b1; gp_auto = 1'b0; hold_len = 0;
    cmd_ctrl = '0; cmd_tl = '0; cmd_br = '0; cmd_arg = '0;
    tick(); tick();
    checks++; if (we_vec !== 4'b0000) begin errors++; $display("FAIL reset_we: got %b want 0000", we_vec); end
    checks++; if (cmd_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cmd_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (cmd_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", cmd_full); end
    checks++; if ({gp_ctrl, gp_tl, gp_br, gp_arg} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {gp_ctrl, gp_tl, gp_br, gp_arg}); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fin_manual = 1'b1;
    push_cmd(32'h1, 32'h000A0014, 32'h00640078, 32'h00000F00);
    checks++; if (cmd_count !== 4'd1) begin errors++; $display("FAIL basic_count_push: got %0d want 1", cmd_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    tick();
    checks++; if (we_vec !== 4'b0000) begin errors++; $display("FAIL basic_fetch_we: got %b want 0000", we_vec); end
    checks++; if (cmd_count !== 4'd0) begin errors++; $display("FAIL basic_count_pop: got %0d want 0", cmd_count); end
    tick();
    checks++; if (we_vec !== 4'b1000) begin errors++; $display("FAIL basic_tl_we: got %b want 1000", we_vec); end
    checks++; if (gp_tl !== 32'h000A0014) begin errors++; $display("FAIL basic_tl_data: got %h want 000a0014", gp_tl); end
    tick();
    checks++; if (we_vec !== 4'b0100) begin errors++; $display("FAIL basic_br_we: got %b want 0100", we_vec); end
    checks++; if (gp_br !== 32'h00640078) begin errors++; $display("FAIL basic_br_data: got %h want 00640078", gp_br); end
    tick();
    checks++; if (we_vec !== 4'b0010) begin errors++; $display("FAIL basic_arg_we: got %b want 0010", we_vec); end
    checks++; if (gp_arg !== 32'h00000F00) begin errors++; $display("FAIL basic_arg_data: got %h want 00000f00", gp_arg); end
    tick();
    checks++; if (we_vec !== 4'b0001) begin errors++; $display("FAIL basic_ctrl_we: got %b want 0001", we_vec); end
    checks++; if (gp_ctrl !== 32'h1) begin errors++; $display("FAIL basic_ctrl_data: got %h want 1", gp_ctrl); end
    tick();
    fin_manual = 1'b0;
    checks++; if (we_vec !== 4'b0000) begin errors++; $display("FAIL basic_post_we: got %b want 0000", we_vec); end
    repeat (9) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_wait: got %b want 1", busy); end
    fin_manual = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    checks++; if (gp_tl !== 32'h000A0014) begin errors++; $display("FAIL basic_data_kept: got %h want 000a0014", gp_tl); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int cyc = 0;
    int last = 0;
    fin_manual = 1'b0; gp_auto = 1'b1; hold_len = 20;
    for (int i = 0; i < 3; i++) push_cmd(32'h11 + i, 32'h21 + i, 32'h31 + i, 32'h41 + i);
    checks++; if (cmd_count !== 4'd3) begin errors++; $display("FAIL b2b_count3: got %0d want 3", cmd_count); end
    fin_manual = 1'b1;
    while (n < 3 && cyc < 300) begin
      tick(); cyc++;
      if (gp_ctrl_we) begin
        checks++; if (gp_finish !== 1'b1) begin errors++; $display("FAIL b2b_ctrl_finish: got %b want 1", gp_finish); end
        checks++; if (gp_ctrl !== 32'h11 + n) begin errors++; $display("FAIL b2b_order: got %h want %h", gp_ctrl, 32'h11 + n); end
        checks++; if (cmd_count !== 4'(2 - n)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", cmd_count, 2 - n); end
        if (n > 0) begin
          checks++; if (cyc - last !== 27) begin errors++; $display("FAIL b2b_spacing: got %0d want 27", cyc - last); end
        end
        last = cyc; n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_issued: got %0d want 3", n); end
    cyc = 0;
    while (busy && cyc < 60) begin tick(); cyc++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", busy); end
    gp_auto = 1'b0;
  endtask

  task automatic test_overflow();
    int n = 0;
    int cyc = 0;
    int extra = 0;
    fin_manual = 1'b0; gp_auto = 1'b0;
    for (int i = 0; i < 8; i++) push_cmd(32'h40 + i, 32'h0, 32'h0, 32'h100 + i);
    checks++; if (cmd_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", cmd_full); end
    checks++; if (cmd_count !== 4'd8) begin errors++; $display("FAIL ovf_count8: got %0d want 8", cmd_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
    push_cmd(32'h99, 32'h0, 32'h0, 32'h999);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (cmd_count !== 4'd8) begin errors++; $display("FAIL ovf_count_drop: got %0d want 8", cmd_count); end
    fin_manual = 1'b1;
    push_cmd(32'hAA, 32'h0, 32'h0, 32'hAAA);
    checks++; if (cmd_count !== 4'd7) begin errors++; $display("FAIL ovf_poppush: got %0d want 7", cmd_count); end
    gp_auto = 1'b1; hold_len = 3;
    while (n < 8 && cyc < 400) begin
      tick(); cyc++;
      if (gp_ctrl_we) begin
        checks++; if (gp_arg !== 32'h100 + n) begin errors++; $display("FAIL ovf_drain_arg: got %h want %h", gp_arg, 32'h100 + n); end
        n++;
      end
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL ovf_drain_cnt: got %0d want 8", n); end
    repeat (40) begin tick(); if (we_vec != 4'b0000) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ovf_extra_issue: got %0d want 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: got %b want 0", busy); end
    gp_auto = 1'b0;
  endtask

  task automatic test_hold_idle();
    int s = 0;
    int cyc = 0;
    fin_manual = 1'b0;
    push_cmd(32'h5, 32'h55, 32'h555, 32'h5555);
    repeat (10) begin tick(); if (we_vec != 4'b0000) s++; end
    checks++; if (s !== 0) begin errors++; $display("FAIL hold_strobes: got %0d want 0", s); end
    checks++; if (cmd_count !== 4'd1) begin errors++; $display("FAIL hold_count: got %0d want 1", cmd_count); end
    fin_manual = 1'b1;
    tick(); tick();
    checks++; if (we_vec !== 4'b1000) begin errors++; $display("FAIL hold_tl_we: got %b want 1000", we_vec); end
    checks++; if (gp_tl !== 32'h55) begin errors++; $display("FAIL hold_tl_data: got %h want 55", gp_tl); end
    tick(); tick(); tick();
    checks++; if (we_vec !== 4'b0001) begin errors++; $display("FAIL hold_ctrl_we: got %b want 0001", we_vec); end
    checks++; if (gp_ctrl !== 32'h5) begin errors++; $display("FAIL hold_ctrl_data: got %h want 5", gp_ctrl); end
    while (busy && cyc < 20) begin tick(); cyc++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    fin_manual = 1'b0;
    push_cmd(32'h61, 32'h62, 32'h63, 32'h64);
    push_cmd(32'h71, 32'h72, 32'h73, 32'h74);
    fin_manual = 1'b1;
    tick();
    checks++; if (cmd_count !== 4'd1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", cmd_count); end
    tick(); tick();
    checks++; if (we_vec !== 4'b0100) begin errors++; $display("FAIL rstmid_br: got %b want 0100", we_vec); end
    rst = 1'b1;
    tick();
    checks++; if (we_vec !== 4'b0000) begin errors++; $display("FAIL rstmid_we: got %b want 0000", we_vec); end
    checks++; if (cmd_count !== 4'd0) begin errors++; $display("FAIL rstmid_cnt0: got %0d want 0", cmd_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    rst = 1'b0;
    push_cmd(32'h81, 32'h82, 32'h83, 32'h84);
    tick(); tick();
    checks++; if (we_vec !== 4'b1000) begin errors++; $display("FAIL rstmid_new_tl: got %b want 1000", we_vec); end
    checks++; if (gp_tl !== 32'h82) begin errors++; $display("FAIL rstmid_new_tldata: got %h want 82", gp_tl); end
    tick(); tick(); tick();
    checks++; if (we_vec !== 4'b0001) begin errors++; $display("FAIL rstmid_new_ctrl: got %b want 0001", we_vec); end
    checks++; if (gp_ctrl !== 32'h81) begin errors++; $display("FAIL rstmid_new_ctrldata: got %h want 81", gp_ctrl); end
    while (busy && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    int s = 0;
    fin_manual = 1'b1;
    push_cmd(32'h91, 32'h92, 32'h93, 32'h94);
`ifdef GPQ_TIMEOUT_EN
    push_cmd(32'hA1, 32'h7B, 32'hA3, 32'hA4);
`endif
    while (!gp_ctrl_we && cyc < 20) begin tick(); cyc++; end
    checks++; if (gp_ctrl_we !== 1'b1) begin errors++; $display("FAIL to_ctrl_seen: got %b want 1", gp_ctrl_we); end
    fin_manual = 1'b0;
`ifdef GPQ_TIMEOUT_EN
    repeat (18) tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", timeout_err); end
    checks++; if (cmd_count !== 4'd1) begin errors++; $display("FAIL to_queued: got %0d want 1", cmd_count); end
    repeat (5) begin tick(); if (we_vec != 4'b0000) s++; end
    checks++; if (s !== 0) begin errors++; $display("FAIL to_hold: got %0d want 0", s); end
    fin_manual = 1'b1;
    tick(); tick();
    checks++; if (we_vec !== 4'b1000) begin errors++; $display("FAIL to_next_tl: got %b want 1000", we_vec); end
    checks++; if (gp_tl !== 32'h7B) begin errors++; $display("FAIL to_next_data: got %h want 7b", gp_tl); end
`else
    repeat (40) tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_disabled: got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_stuck_busy: got %b want 1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    fin_manual = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_cleanup: got %b want 0", busy); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_hold_idle();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
